xvec2_md_issue: RTL and testbench

// - Initiator/sequencer for the xvec2 mul/div responder. Accepts one vector MUL/DIV/REM command from the xvec2 pipeline.
// - Splits both VEC_XPR_LEN operands into NUM_LANES elements of XPR_LEN bits each.
// - Issues one request per enabled lane to the scalar md unit (req_valid/req_ready, then resp_valid/resp_result).
// - Gathers the lane results and returns the assembled vector result with a valid/ready handshake.

---
 rtl/xvec2_md_issue_pkg.sv | 27 ++
 rtl/xvec2_md_issue_if.sv | 59 +++++
 rtl/xvec2_md_lane_sel.sv | 17 +
 rtl/xvec2_md_issue.sv | 147 ++++++++++++++
 tb/tb_xvec2_md_issue.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/xvec2_md_issue_pkg.sv
// rtl/xvec2_md_issue_pkg.sv - shared op/out_sel encodings and sequencer state type
package xvec2_md_issue_pkg;

  localparam int MD_OP_WIDTH      = 2;
  localparam int MD_OUT_SEL_WIDTH = 2;

  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = 2'd0;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = 2'd1;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // True for ops whose divisor operand can be zero
  function automatic logic is_div_op(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/xvec2_md_issue_if.sv
// rtl/xvec2_md_issue_if.sv - command, md request/response and done bus of the vector md sequencer
interface xvec2_md_issue_if
  import xvec2_md_issue_pkg::*;
#(
  parameter int XPR_LEN   = 32,
  parameter int NUM_LANES = 4
);
  localparam int VEC_XPR_LEN = XPR_LEN * NUM_LANES;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [MD_OP_WIDTH-1:0]      cmd_op;
  logic [MD_OUT_SEL_WIDTH-1:0] cmd_out_sel;
  logic                        cmd_in_1_signed;
  logic                        cmd_in_2_signed;
  logic [VEC_XPR_LEN-1:0]      cmd_in_1;
  logic [VEC_XPR_LEN-1:0]      cmd_in_2;
  logic [NUM_LANES-1:0]        cmd_mask;

  logic                        md_req_valid;
  logic                        md_req_ready;
  logic [MD_OP_WIDTH-1:0]      md_req_op;
  logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel;
  logic                        md_req_in_1_signed;
  logic                        md_req_in_2_signed;
  logic [XPR_LEN-1:0]          md_req_in_1;
  logic [XPR_LEN-1:0]          md_req_in_2;
  logic                        md_resp_valid;
  logic [XPR_LEN-1:0]          md_resp_result;

  logic                        done_valid;
  logic                        done_ready;
  logic [VEC_XPR_LEN-1:0]      done_result;

  // Sequencer side
  modport master (
    input  cmd_valid, cmd_op, cmd_out_sel, cmd_in_1_signed, cmd_in_2_signed,
           cmd_in_1, cmd_in_2, cmd_mask,
    output cmd_ready,
    output md_req_valid, md_req_op, md_req_out_sel, md_req_in_1_signed,
           md_req_in_2_signed, md_req_in_1, md_req_in_2,
    input  md_req_ready, md_resp_valid, md_resp_result,
    output done_valid, done_result,
    input  done_ready
  );

  // Pipeline / md unit / consumer side
  modport slave (
    output cmd_valid, cmd_op, cmd_out_sel, cmd_in_1_signed, cmd_in_2_signed,
           cmd_in_1, cmd_in_2, cmd_mask,
    input  cmd_ready,
    input  md_req_valid, md_req_op, md_req_out_sel, md_req_in_1_signed,
           md_req_in_2_signed, md_req_in_1, md_req_in_2,
    output md_req_ready, md_resp_valid, md_resp_result,
    input  done_valid, done_result,
    output done_ready
  );

endinterface

// File: rtl/xvec2_md_lane_sel.sv
// rtl/xvec2_md_lane_sel.sv - combinational extract of one XPR_LEN element from a packed vector
module xvec2_md_lane_sel #(
  parameter int XPR_LEN   = 32,
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic [XPR_LEN*NUM_LANES-1:0] vec_i,
  input  logic [LANE_W-1:0]            idx_i,
  output logic [XPR_LEN-1:0]           elem_o
);

  // Lane i occupies bits [i*XPR_LEN +: XPR_LEN]
  always_comb begin
    elem_o = vec_i[int'(idx_i)*XPR_LEN +: XPR_LEN];
  end

endmodule

// File: rtl/xvec2_md_issue.sv
// rtl/xvec2_md_issue.sv - vector MUL/DIV/REM sequencer over a scalar md unit; option XVEC2_MD_DIV0_BYPASS_EN
module xvec2_md_issue
  import xvec2_md_issue_pkg::*;
#(
  parameter int XPR_LEN   = 32,
  parameter int NUM_LANES = 4
) (
  input  logic             clk,
  input  logic             reset,
  xvec2_md_issue_if.master bus
);

  localparam int VEC_XPR_LEN = XPR_LEN * NUM_LANES;
  localparam int LANE_W      = $clog2(NUM_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  state_e                      state_q, state_d;
  logic [LANE_W-1:0]           lane_q, lane_d;
  logic [MD_OP_WIDTH-1:0]      op_q;
  logic [MD_OUT_SEL_WIDTH-1:0] out_sel_q;
  logic                        in_1_signed_q, in_2_signed_q;
  logic [VEC_XPR_LEN-1:0]      in_1_q, in_2_q, result_q;
  logic [NUM_LANES-1:0]        mask_q;

  logic [XPR_LEN-1:0]          lane_in_1, lane_in_2;
  logic                        lane_en, div0_bypass;
  logic                        accept, advance, wr_en;
  logic [XPR_LEN-1:0]          wr_data;

  xvec2_md_lane_sel #(.XPR_LEN(XPR_LEN), .NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) u_sel_in_1 (
    .vec_i (in_1_q),
    .idx_i (lane_q),
    .elem_o(lane_in_1)
  );

  xvec2_md_lane_sel #(.XPR_LEN(XPR_LEN), .NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) u_sel_in_2 (
    .vec_i (in_2_q),
    .idx_i (lane_q),
    .elem_o(lane_in_2)
  );

  assign lane_en = mask_q[lane_q];

`ifdef XVEC2_MD_DIV0_BYPASS_EN
  // Divide by zero is resolved locally without bothering the md unit
  assign div0_bypass = is_div_op(op_q) && (lane_in_2 == '0);
`else
  assign div0_bypass = 1'b0;
`endif

  // Next-state, lane advance and result-slot write selection
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    accept  = 1'b0;
    advance = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          lane_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!lane_en) begin
          wr_en   = 1'b1;
          wr_data = lane_in_1;
          advance = 1'b1;
        end else if (div0_bypass) begin
          wr_en   = 1'b1;
          wr_data = (out_sel_q == MD_OUT_REM) ? lane_in_1 : '1;
          advance = 1'b1;
        end else if (bus.md_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.md_resp_valid) begin
          wr_en   = 1'b1;
          wr_data = bus.md_resp_result;
          advance = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.done_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (lane_q == LAST_LANE) begin
        state_d = S_DONE;
      end else begin
        lane_d  = lane_q + 1'b1;
        state_d = S_ISSUE;
      end
    end
  end

  // State, command latch and result assembly registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      lane_q        <= '0;
      op_q          <= '0;
      out_sel_q     <= '0;
      in_1_signed_q <= 1'b0;
      in_2_signed_q <= 1'b0;
      in_1_q        <= '0;
      in_2_q        <= '0;
      mask_q        <= '0;
      result_q      <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (accept) begin
        op_q          <= bus.cmd_op;
        out_sel_q     <= bus.cmd_out_sel;
        in_1_signed_q <= bus.cmd_in_1_signed;
        in_2_signed_q <= bus.cmd_in_2_signed;
        in_1_q        <= bus.cmd_in_1;
        in_2_q        <= bus.cmd_in_2;
        mask_q        <= bus.cmd_mask;
        result_q      <= '0;
      end else if (wr_en) begin
        result_q[int'(lane_q)*XPR_LEN +: XPR_LEN] <= wr_data;
      end
    end
  end

  // cmd_ready is held low while reset is asserted so every output reads 0 in reset
  assign bus.cmd_ready          = reset && (state_q == S_IDLE);
  assign bus.md_req_valid       = (state_q == S_ISSUE) && lane_en && !div0_bypass;
  assign bus.md_req_op          = op_q;
  assign bus.md_req_out_sel     = out_sel_q;
  assign bus.md_req_in_1_signed = in_1_signed_q;
  assign bus.md_req_in_2_signed = in_2_signed_q;
  assign bus.md_req_in_1        = lane_in_1;
  assign bus.md_req_in_2        = lane_in_2;
  assign bus.done_valid         = (state_q == S_DONE);
  assign bus.done_result        = result_q;

endmodule

// File: tb/tb_xvec2_md_issue.sv
// tb/tb_xvec2_md_issue.sv - directed self-checking bench for xvec2_md_issue
module tb_xvec2_md_issue;
  import xvec2_md_issue_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  xvec2_md_issue_if #(.XPR_LEN(32), .NUM_LANES(4)) bus();

  xvec2_md_issue #(.XPR_LEN(32), .NUM_LANES(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // responder configuration (written by the main sequence only)
  int ready_dly = 0;
  int resp_dly  = 0;
  bit stray_en  = 1'b0;

  // responder state (written by the responder only)
  int rphase = 0, rcnt = 0, hs_count = 0, stable_err = 0;
  logic [31:0] hold_a, hold_b, resp_val;
  logic cap_s1, cap_s2;

  function automatic logic [31:0] md_model(input logic [1:0] op, input logic [1:0] sel,
                                           input logic s1, input logic s2,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] pa, pb;
    logic signed [65:0] prod;
    pa = s1 ? {a[31], a} : {1'b0, a};
    pb = s2 ? {b[31], b} : {1'b0, b};
    prod = pa * pb;
    if (op == MD_OP_MUL) return (sel == MD_OUT_HI) ? prod[63:32] : prod[31:0];
    if (b == 32'd0) return (op == MD_OP_REM) ? a : 32'hFFFF_FFFF;
    if (op == MD_OP_DIV) return (s1 && s2) ? 32'($signed(a) / $signed(b)) : a / b;
    return (s1 && s2) ? 32'($signed(a) % $signed(b)) : a % b;
  endfunction

  // scalar md unit model: ready after ready_dly stall cycles, response resp_dly cycles into WAIT
  initial begin
    bus.md_req_ready   = 1'b0;
    bus.md_resp_valid  = 1'b0;
    bus.md_resp_result = '0;
    forever begin
      @(negedge clk);
      bus.md_req_ready  = 1'b0;
      bus.md_resp_valid = 1'b0;
      if (rphase == 0) begin
        if (bus.md_req_valid === 1'b1) begin
          if (rcnt == 0) begin
            hold_a = bus.md_req_in_1;
            hold_b = bus.md_req_in_2;
          end else if (bus.md_req_in_1 !== hold_a || bus.md_req_in_2 !== hold_b) begin
            stable_err++;
          end
          if (rcnt >= ready_dly) begin
            bus.md_req_ready = 1'b1;
            cap_s1   = bus.md_req_in_1_signed;
            cap_s2   = bus.md_req_in_2_signed;
            resp_val = md_model(bus.md_req_op, bus.md_req_out_sel, bus.md_req_in_1_signed,
                                bus.md_req_in_2_signed, bus.md_req_in_1, bus.md_req_in_2);
            hs_count++;
            rphase = 1;
            rcnt   = 0;
          end else begin
            rcnt++;
            if (stray_en) begin
              bus.md_resp_valid  = 1'b1;
              bus.md_resp_result = 32'hDEAD_BEEF;
            end
          end
        end else if (rcnt != 0) begin
          stable_err++;
          rcnt = 0;
        end
      end else begin
        if (rcnt >= resp_dly) begin
          bus.md_resp_valid  = 1'b1;
          bus.md_resp_result = resp_val;
          rphase = 0;
          rcnt   = 0;
        end else begin
          rcnt++;
        end
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] sel, input logic s1,
                          input logic s2, input logic [127:0] in1, input logic [127:0] in2,
                          input logic [3:0] mask);
    @(negedge clk);
    bus.cmd_valid       = 1'b1;
    bus.cmd_op          = op;
    bus.cmd_out_sel     = sel;
    bus.cmd_in_1_signed = s1;
    bus.cmd_in_2_signed = s2;
    bus.cmd_in_1        = in1;
    bus.cmd_in_2        = in2;
    bus.cmd_mask        = mask;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // cycles from the accept cycle to the first DONE cycle; -1 on timeout
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.done_valid !== 1'b1) begin
      if (cyc > 300) begin
        cyc = -1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume();
    bus.done_ready = 1'b1;
    @(negedge clk);
    bus.done_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready: got %0b want 0", bus.cmd_ready); end
    n_cmp++; if (bus.md_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %0b want 0", bus.md_req_valid); end
    n_cmp++; if (bus.done_valid !== 1'b0) begin n_bad++; $display("FAIL reset_done_valid: got %0b want 0", bus.done_valid); end
    n_cmp++; if (bus.done_result !== 128'd0) begin n_bad++; $display("FAIL reset_done_result: got %0h want 0", bus.done_result); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %0b want 1", bus.cmd_ready); end
  endtask

  task automatic test_mul_full();
    int lat, hs0;
    hs0 = hs_count;
    send_cmd(MD_OP_MUL, MD_OUT_LO, 1'b0, 1'b0, {32'd5, 32'd4, 32'd3, 32'd2}, {4{32'd10}}, 4'b1111);
    wait_done(lat);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL mul_latency: got %0d want 9", lat); end
    n_cmp++; if (bus.done_result !== {32'd50, 32'd40, 32'd30, 32'd20}) begin n_bad++; $display("FAIL mul_result: got %0h want 50/40/30/20", bus.done_result); end
    n_cmp++; if (hs_count - hs0 !== 4) begin n_bad++; $display("FAIL mul_handshakes: got %0d want 4", hs_count - hs0); end
    consume();
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mul_back_idle: got %0b want 1", bus.cmd_ready); end
  endtask

  task automatic test_mask();
    int lat, hs0;
    hs0 = hs_count;
    send_cmd(MD_OP_MUL, MD_OUT_LO, 1'b0, 1'b0, {32'd6, 32'd9, 32'd8, 32'd7}, {4{32'd3}}, 4'b0101);
    wait_done(lat);
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL mask_latency: got %0d want 7", lat); end
    n_cmp++; if (bus.done_result !== {32'd6, 32'd27, 32'd8, 32'd21}) begin n_bad++; $display("FAIL mask_result: got %0h want 6/27/8/21", bus.done_result); end
    n_cmp++; if (hs_count - hs0 !== 2) begin n_bad++; $display("FAIL mask_handshakes: got %0d want 2", hs_count - hs0); end
    consume();
  endtask

  task automatic test_mask_zero();
    int lat, hs0;
    hs0 = hs_count;
    send_cmd(MD_OP_DIV, MD_OUT_LO, 1'b0, 1'b0, 128'h44444444_33333333_22222222_11111111, 128'd0, 4'b0000);
    wait_done(lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL zero_mask_latency: got %0d want 5", lat); end
    n_cmp++; if (bus.done_result !== 128'h44444444_33333333_22222222_11111111) begin n_bad++; $display("FAIL zero_mask_result: got %0h want passthrough", bus.done_result); end
    n_cmp++; if (hs_count - hs0 !== 0) begin n_bad++; $display("FAIL zero_mask_handshakes: got %0d want 0", hs_count - hs0); end
    consume();
  endtask

  task automatic test_stall();
    int lat, hs0, se0;
    hs0 = hs_count;
    se0 = stable_err;
    ready_dly = 5;
    resp_dly  = 33;
    stray_en  = 1'b1;
    send_cmd(MD_OP_MUL, MD_OUT_LO, 1'b0, 1'b0, {32'd3, 32'd2, 32'd1, 32'd6}, {4{32'd7}}, 4'b0001);
    wait_done(lat);
    ready_dly = 0;
    resp_dly  = 0;
    stray_en  = 1'b0;
    n_cmp++; if (lat !== 44) begin n_bad++; $display("FAIL stall_latency: got %0d want 44", lat); end
    n_cmp++; if (bus.done_result !== {32'd3, 32'd2, 32'd1, 32'd42}) begin n_bad++; $display("FAIL stall_result: got %0h want 3/2/1/42", bus.done_result); end
    n_cmp++; if (stable_err - se0 !== 0) begin n_bad++; $display("FAIL stall_stability: got %0d changes want 0", stable_err - se0); end
    n_cmp++; if (hs_count - hs0 !== 1) begin n_bad++; $display("FAIL stall_handshakes: got %0d want 1", hs_count - hs0); end
    consume();
  endtask

  task automatic test_div_signed();
    int lat;
    send_cmd(MD_OP_DIV, MD_OUT_LO, 1'b1, 1'b1, {96'd0, 32'hFFFF_FFF9}, {96'd0, 32'd2}, 4'b0001);
    wait_done(lat);
    n_cmp++; if (cap_s1 !== 1'b1 || cap_s2 !== 1'b1) begin n_bad++; $display("FAIL div_signed_flags: got %0b%0b want 11", cap_s1, cap_s2); end
    n_cmp++; if (bus.done_result !== {96'd0, 32'hFFFF_FFFD}) begin n_bad++; $display("FAIL div_signed_result: got %0h want fffffffd", bus.done_result); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.done_valid !== 1'b1) begin n_bad++; $display("FAIL done_hold_valid[%0d]: got %0b want 1", i, bus.done_valid); end
      n_cmp++; if (bus.done_result !== {96'd0, 32'hFFFF_FFFD}) begin n_bad++; $display("FAIL done_hold_result[%0d]: got %0h want fffffffd", i, bus.done_result); end
    end
    consume();
  endtask

  task automatic test_div0();
    int lat, hs0, want_hs;
`ifdef XVEC2_MD_DIV0_BYPASS_EN
    want_hs = 0;
`else
    want_hs = 1;
`endif
    hs0 = hs_count;
    send_cmd(MD_OP_DIV, MD_OUT_LO, 1'b0, 1'b0, {96'd0, 32'd9}, 128'd0, 4'b0001);
    wait_done(lat);
    n_cmp++; if (bus.done_result !== {96'd0, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL div0_div_result: got %0h want ffffffff", bus.done_result); end
    n_cmp++; if (hs_count - hs0 !== want_hs) begin n_bad++; $display("FAIL div0_div_handshakes: got %0d want %0d", hs_count - hs0, want_hs); end
    consume();
    hs0 = hs_count;
    send_cmd(MD_OP_REM, MD_OUT_REM, 1'b0, 1'b0, {96'd0, 32'd9}, 128'd0, 4'b0001);
    wait_done(lat);
    n_cmp++; if (bus.done_result !== {96'd0, 32'd9}) begin n_bad++; $display("FAIL div0_rem_result: got %0h want 9", bus.done_result); end
    n_cmp++; if (hs_count - hs0 !== want_hs) begin n_bad++; $display("FAIL div0_rem_handshakes: got %0d want %0d", hs_count - hs0, want_hs); end
    consume();
  endtask

  task automatic test_reset_mid();
    bit seen;
    resp_dly = 5;
    send_cmd(MD_OP_MUL, MD_OUT_LO, 1'b0, 1'b0, {96'd0, 32'd3}, {96'd0, 32'd4}, 4'b0001);
    @(negedge clk);
    n_cmp++; if (bus.md_req_in_1 !== 32'd3) begin n_bad++; $display("FAIL mid_pre_operand: got %0h want 3", bus.md_req_in_1); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL mid_cmd_ready: got %0b want 0", bus.cmd_ready); end
    n_cmp++; if (bus.md_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_req_valid: got %0b want 0", bus.md_req_valid); end
    n_cmp++; if (bus.md_req_in_1 !== 32'd0 || bus.md_req_in_2 !== 32'd0) begin n_bad++; $display("FAIL mid_operands: got %0h/%0h want 0/0", bus.md_req_in_1, bus.md_req_in_2); end
    n_cmp++; if (bus.done_valid !== 1'b0 || bus.done_result !== 128'd0) begin n_bad++; $display("FAIL mid_done: got %0b/%0h want 0/0", bus.done_valid, bus.done_result); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_release_ready: got %0b want 1", bus.cmd_ready); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done_valid === 1'b1) seen = 1'b1;
    end
    resp_dly = 0;
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_late_resp_done: got %0b want 0", seen); end
  endtask

  initial begin
    bus.cmd_valid       = 1'b0;
    bus.cmd_op          = '0;
    bus.cmd_out_sel     = '0;
    bus.cmd_in_1_signed = 1'b0;
    bus.cmd_in_2_signed = 1'b0;
    bus.cmd_in_1        = '0;
    bus.cmd_in_2        = '0;
    bus.cmd_mask        = '0;
    bus.done_ready      = 1'b0;
    test_reset();
    test_mul_full();
    test_mask();
    test_mask_zero();
    test_stall();
    test_div_signed();
    test_div0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
